nibble_serial_add_ctrl: RTL and testbench

- Sequencer that performs a WIDTH-bit add by time-multiplexing one 4-bit ripple-carry adder (nibble_adder), one nibble per cycle, LSB nibble first.
- The carry is registered between nibbles.
- Operands enter through a valid/ready handshake. The result leaves through a second valid/ready handshake.
- Serves as the area-reduced wide adder for datapaths that do not need single-cycle addition.

---
 rtl/nibble_add_pkg.sv | 17 +
 rtl/nibble_adder.sv | 21 ++
 rtl/nibble_serial_add_ctrl.sv | 146 ++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
// The optional subtract mode is selected by the NIBBLE_SUB_EN macro in the top module.
package nibble_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_state_t;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple-carry adder built from four full-adder cells.
module nibble_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder that reuses one nibble_adder, one nibble per cycle, LSB first.
// Define NIBBLE_SUB_EN to add the sub input (a-b) and the signed-overflow output ovf.
module nibble_serial_add_ctrl
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef NIBBLE_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output add_state_t       dbg_state
);

  localparam int NIB = nib_count(WIDTH);
  localparam int CW  = (NIB == 1) ? 1 : $clog2(NIB);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid is high only in DONE.
  add_state_t       r_state, w_next_state;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       w_a_nib, w_b_nib, w_b_eff, w_nib_sum;
  logic             w_nib_cout, w_last;

  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int k = 0; k < NIB; k++) begin
      if (r_cnt == CW'(k)) begin
        w_a_nib = r_a[k*NIBBLE_W +: NIBBLE_W];
        w_b_nib = r_b[k*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  assign w_last = (r_cnt == CW'(NIB - 1));

`ifdef NIBBLE_SUB_EN
  logic r_sub, r_ovf, w_ovf;
  assign w_b_eff = r_sub ? ~w_b_nib : w_b_nib;
  // Carry into the MSB cell is recovered from its sum bit; XOR with carry out gives signed overflow.
  assign w_ovf   = w_nib_sum[3] ^ w_a_nib[3] ^ w_b_eff[3] ^ w_nib_cout;
  assign ovf     = r_ovf;
`else
  assign w_b_eff = w_b_nib;
`endif

  nibble_adder u_nibble_adder (
    .a   (w_a_nib),
    .b   (w_b_eff),
    .cin (r_carry),
    .sum (w_nib_sum),
    .cout(w_nib_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next_state = RUN;
      RUN:     if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cout      = 1'b0;
    case (r_state)
      IDLE: in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        cout      = r_carry;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
`ifdef NIBBLE_SUB_EN
      r_sub   <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= b;
          r_sum   <= '0;
          r_cnt   <= '0;
`ifdef NIBBLE_SUB_EN
          r_carry <= sub | cin;
          r_sub   <= sub;
          r_ovf   <= 1'b0;
`else
          r_carry <= cin;
`endif
        end
        RUN: begin
          r_carry <= w_nib_cout;
          r_cnt   <= r_cnt + CW'(1);
          for (int k = 0; k < NIB; k++) begin
            if (r_cnt == CW'(k)) r_sum[k*NIBBLE_W +: NIBBLE_W] <= w_nib_sum;
          end
`ifdef NIBBLE_SUB_EN
          if (w_last) r_ovf <= w_ovf;
`endif
        end
        default: ;
      endcase
    end
  end

  assign sum       = r_sum;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl: vector table, directed corner cases and
// randomized operations against an arithmetic reference model (NIBBLE_SUB_EN adds an 8-bit instance).
module tb_nibble_serial_add_ctrl;
  import nibble_add_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- WIDTH=16 instance ----------------
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [15:0] a, b, sum;
  add_state_t  st;
  // ---------------- WIDTH=4 instance ----------------
  logic        v4_in_valid, v4_in_ready, v4_cin, v4_out_valid, v4_out_ready, v4_cout;
  logic [3:0]  v4_a, v4_b, v4_sum;
  add_state_t  v4_st;
`ifdef NIBBLE_SUB_EN
  logic        ovf16, ovf4;
  logic        s8_in_valid, s8_in_ready, s8_cin, s8_out_valid, s8_out_ready, s8_cout, s8_sub, s8_ovf;
  logic [7:0]  s8_a, s8_b, s8_sum;
  add_state_t  s8_st;
`endif

  nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
`ifdef NIBBLE_SUB_EN
    .sub(1'b0), .ovf(ovf16),
`endif
    .dbg_state(st)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4_in_valid), .in_ready(v4_in_ready), .a(v4_a), .b(v4_b),
    .cin(v4_cin), .out_valid(v4_out_valid), .out_ready(v4_out_ready), .sum(v4_sum), .cout(v4_cout),
`ifdef NIBBLE_SUB_EN
    .sub(1'b0), .ovf(ovf4),
`endif
    .dbg_state(v4_st)
  );

`ifdef NIBBLE_SUB_EN
  nibble_serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(s8_in_valid), .in_ready(s8_in_ready), .a(s8_a), .b(s8_b),
    .cin(s8_cin), .out_valid(s8_out_valid), .out_ready(s8_out_ready), .sum(s8_sum), .cout(s8_cout),
    .sub(s8_sub), .ovf(s8_ovf), .dbg_state(s8_st)
  );
`endif

  // ---------------- scoreboard ----------------
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [16:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // lat counts edges from the accepting edge (edge 1) to the edge that raises out_valid.
  task automatic do_op16(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                         input int bp, input bit rnd_ready,
                         output logic [15:0] rsum, output logic rcout, output int lat);
    int guard;
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb; cin = tcin;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 16'hAAAA; b = 16'hAAAA; cin = 1'b0;
    lat = 1;
    while (lat < 50) begin
      @(negedge clk);
      if (out_valid) break;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      lat++;
    end
    if (lat >= 50) chk("result_timeout", 0, 1);
    out_ready = 1'b0;
    rsum  = sum;
    rcout = cout;
    repeat (bp) begin
      @(negedge clk);
      chk("bp_sum_stable", 32'(sum), 32'(rsum));
      chk("bp_cout_stable", 32'(cout), 32'(rcout));
      chk("bp_in_ready_low", 32'(in_ready), 0);
      chk("bp_out_valid_high", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_in_ready", 32'(in_ready), 1);
    chk("post_hs_out_valid", 32'(out_valid), 0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] rs;
    logic        rc;
    int          lat;
    logic [16:0] e;
    int          acc_q[$];

    rst = 1'b1;
    in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 0;
    v4_in_valid = 0; v4_a = 0; v4_b = 0; v4_cin = 0; v4_out_ready = 0;
`ifdef NIBBLE_SUB_EN
    s8_in_valid = 0; s8_a = 0; s8_b = 0; s8_cin = 0; s8_out_ready = 0; s8_sub = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_state", 32'(st), 32'(IDLE));
    chk("rst4_in_ready", 32'(v4_in_ready), 1);
    rst = 1'b0;

    // ---------------- vector table ----------------
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_op16(vecs[i].a, vecs[i].b, vecs[i].cin, 0, 1'b0, rs, rc, lat);
      chk($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].cout));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 5);
    end

    // ---------------- backpressure: 10 cycles held in DONE ----------------
    do_op16(16'h1234, 16'h4321, 1'b1, 10, 1'b0, rs, rc, lat);
    chk("bp_sum", 32'(rs), 32'h5556);
    chk("bp_cout", 32'(rc), 0);

    // ---------------- reset on the 2nd RUN cycle ----------------
    @(negedge clk);
    in_valid = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_state", 32'(st), 32'(IDLE));
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_sum", 32'(sum), 0);
    chk("midrst_cout", 32'(cout), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    do_op16(16'h00FF, 16'h0001, 1'b0, 0, 1'b0, rs, rc, lat);
    chk("after_rst_sum", 32'(rs), 32'h0100);
    chk("after_rst_cout", 32'(rc), 0);

    // ---------------- randomized operations vs arithmetic model ----------------
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      logic        rci;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rci = 1'($urandom_range(0, 1));
      exp_q.push_back(17'(ra) + 17'(rb) + 17'(rci));
      do_op16(ra, rb, rci, $urandom_range(0, 3), 1'b1, rs, rc, lat);
      e = exp_q.pop_front();
      chk($sformatf("rnd%0d_sum", i), 32'(rs), 32'(e[15:0]));
      chk($sformatf("rnd%0d_cout", i), 32'(rc), 32'(e[16]));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 5);
    end

    // ---------------- WIDTH=4 instance ----------------
    @(negedge clk);
    v4_in_valid = 1'b1; v4_a = 4'hF; v4_b = 4'h1; v4_cin = 1'b1;
    @(posedge clk);
    #1 v4_in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (v4_out_valid) break;
      lat++;
    end
    chk("w4_latency", 32'(lat), 2);
    chk("w4_sum", 32'(v4_sum), 32'h1);
    chk("w4_cout", 32'(v4_cout), 1);
    v4_out_ready = 1'b1;
    @(posedge clk);
    #1 v4_out_ready = 1'b0;
    @(negedge clk);
    chk("w4_back_idle", 32'(v4_in_ready), 1);

    // back-to-back: in_valid and out_ready held high, accepts every NIB+2 = 3 cycles
    v4_in_valid = 1'b1; v4_out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) @(negedge clk);
      if (v4_in_ready) acc_q.push_back(cyc);
      if (v4_out_valid) begin
        chk("w4_b2b_sum", 32'(v4_sum), 32'h1);
        chk("w4_b2b_cout", 32'(v4_cout), 1);
      end
    end
    v4_in_valid = 1'b0; v4_out_ready = 1'b0;
    chk("w4_b2b_accepts", 32'(acc_q.size()), 5);
    for (int i = 1; i < acc_q.size(); i++)
      chk($sformatf("w4_b2b_interval%0d", i), 32'(acc_q[i] - acc_q[i-1]), 3);

`ifdef NIBBLE_SUB_EN
    // ---------------- subtract mode on WIDTH=8 ----------------
    for (int i = 0; i < 22; i++) begin
      logic [7:0] ta, tb, beff, es;
      logic       tsub, tci, ec, eo;
      logic [8:0] full;
      if (i == 0)      begin ta = 8'h80; tb = 8'h01; tsub = 1'b1; tci = 1'b0; end
      else if (i == 1) begin ta = 8'h05; tb = 8'h07; tsub = 1'b1; tci = 1'b0; end
      else begin
        ta = 8'($urandom); tb = 8'($urandom);
        tsub = 1'($urandom_range(0, 1)); tci = 1'($urandom_range(0, 1));
      end
      beff = tsub ? ~tb : tb;
      full = 9'(ta) + 9'(beff) + 9'(tsub ? 1'b1 : tci);
      es = full[7:0];
      ec = full[8];
      eo = (ta[7] == beff[7]) && (es[7] != ta[7]);
      @(negedge clk);
      s8_in_valid = 1'b1; s8_a = ta; s8_b = tb; s8_sub = tsub; s8_cin = tci;
      @(posedge clk);
      #1 s8_in_valid = 1'b0; s8_sub = ~tsub; s8_cin = ~tci;
      lat = 1;
      while (lat < 20) begin
        @(negedge clk);
        if (s8_out_valid) break;
        lat++;
      end
      chk($sformatf("sub%0d_latency", i), 32'(lat), 3);
      chk($sformatf("sub%0d_sum", i), 32'(s8_sum), 32'(es));
      chk($sformatf("sub%0d_cout", i), 32'(s8_cout), 32'(ec));
      chk($sformatf("sub%0d_ovf", i), 32'(s8_ovf), 32'(eo));
      s8_out_ready = 1'b1;
      @(posedge clk);
      #1 s8_out_ready = 1'b0;
    end
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
